// File: rtl/u712_chip_ram_arbiter_if.sv
// Request/dispatch bundle between the U712 chip-RAM arbiter and its
// requesters (Agnus DMA, CPU) and the SDRAM sequencer.
interface u712_chip_ram_arbiter_if;
    logic       CFG_DONE;
    logic       DMA_REQ;
    logic       DMA_WRITE;
    logic       DBR_ACTIVE;
    logic       CPU_REQ;
    logic       CPU_WRITE;
    logic       SEQ_DONE;
    logic       SEQ_START;
    logic [1:0] SEQ_OP;
    logic       SEQ_WRITE;
    logic       CPU_GRANT;
    logic [2:0] REF_PENDING;
    logic       BUSY;
    logic       DMA_OVERRUN;
    logic       REF_OVERRUN;
    logic       SEQ_TIMEOUT;

    // Requester/sequencer side: drives requests and completion.
    modport master (
        output CFG_DONE, DMA_REQ, DMA_WRITE, DBR_ACTIVE, CPU_REQ, CPU_WRITE, SEQ_DONE,
        input  SEQ_START, SEQ_OP, SEQ_WRITE, CPU_GRANT, REF_PENDING, BUSY,
               DMA_OVERRUN, REF_OVERRUN, SEQ_TIMEOUT
    );

    // Arbiter side: consumes requests, issues dispatch strobes.
    modport slave (
        input  CFG_DONE, DMA_REQ, DMA_WRITE, DBR_ACTIVE, CPU_REQ, CPU_WRITE, SEQ_DONE,
        output SEQ_START, SEQ_OP, SEQ_WRITE, CPU_GRANT, REF_PENDING, BUSY,
               DMA_OVERRUN, REF_OVERRUN, SEQ_TIMEOUT
    );
endinterface

// File: rtl/u712_chip_ram_arbiter.sv
// U712 chip-RAM request arbiter: picks one of DMA / refresh / CPU per
// sequencer cycle, keeps CPU and refresh ops clear of the next Agnus slot,
// tracks owed refreshes and recovers from a hung sequencer.
// All state updates on the falling edge of CLK80.
module u712_chip_ram_arbiter #(
    parameter logic [9:0] REF_INTERVAL    = 10'd620,
    parameter logic [2:0] REF_DEBT_MAX    = 3'd4,
    parameter logic [7:0] DMA_SLOT_PERIOD = 8'd22,
    parameter logic [7:0] CPU_LEN         = 8'd7,
    parameter logic [7:0] REF_LEN         = 8'd5,
    parameter logic [7:0] TIMEOUT         = 8'd32
) (
    input logic                    CLK80,
    input logic                    RESET,
    u712_chip_ram_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_REF  = 2'b01,
        OP_CPU  = 2'b10,
        OP_DMA  = 2'b11
    } op_e;

    state_e     state;
    op_e        seq_op;
    logic       seq_start;
    logic       seq_write;
    logic       cpu_grant;
    logic       busy;
    logic       dma_overrun;
    logic       ref_overrun;
    logic       seq_timeout;
    logic [9:0] tick_cnt;
    logic [2:0] ref_pending;
    logic [7:0] slot_cnt;
    logic [7:0] wdog;
    logic       dma_pend;
    logic       dma_pend_wr;
    logic       cpu_armed;

    logic       tick_wrap;
    logic [7:0] remain;
    logic       cpu_fits;
    logic       ref_fits;
    op_e        disp_op;
    logic       disp_write;

    assign tick_wrap = (tick_cnt == REF_INTERVAL - 10'd1);
    assign remain    = (slot_cnt >= DMA_SLOT_PERIOD) ? 8'd0 : (DMA_SLOT_PERIOD - slot_cnt);
    assign cpu_fits  = !bus.DBR_ACTIVE || (remain > CPU_LEN);
    assign ref_fits  = !bus.DBR_ACTIVE || (remain > REF_LEN);

    // Pick the op to dispatch this clock, if any, in fixed priority order.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        disp_op    = OP_NONE;
        disp_write = 1'b0;
        if (state == ST_IDLE && bus.CFG_DONE) begin
            if (bus.DMA_REQ || dma_pend) begin
                disp_op    = OP_DMA;
                disp_write = bus.DMA_REQ ? bus.DMA_WRITE : dma_pend_wr;
            end else if (ref_pending == REF_DEBT_MAX) begin
                disp_op = OP_REF;
            end else if (bus.CPU_REQ && cpu_armed && cpu_fits) begin
                disp_op    = OP_CPU;
                disp_write = bus.CPU_WRITE;
            end else if (ref_pending != 3'd0 && ref_fits) begin
                disp_op = OP_REF;
            end
        end
    end

    // Refresh tick counter and owed-refresh accounting.
    always_ff @(negedge CLK80) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (RESET) begin
            tick_cnt    <= 10'd0;
            ref_pending <= 3'd0;
            ref_overrun <= 1'b0;
        end else begin
            tick_cnt <= tick_wrap ? 10'd0 : tick_cnt + 10'd1;
            if (tick_wrap && disp_op != OP_REF) begin
                if (ref_pending != REF_DEBT_MAX)
                    ref_pending <= ref_pending + 3'd1;
            end else if (!tick_wrap && disp_op == OP_REF) begin
                ref_pending <= ref_pending - 3'd1;
            end
            if (tick_wrap && ref_pending == REF_DEBT_MAX)
                ref_overrun <= 1'b1;
        end
    end

    // Clocks since the last Agnus slot start, saturating.
    always_ff @(negedge CLK80) begin
        if (RESET)
            slot_cnt <= 8'd0;
        else if (bus.DMA_REQ)
            slot_cnt <= 8'd0;
        else if (slot_cnt != 8'hFF)
            slot_cnt <= slot_cnt + 8'd1;
    end

    // Hold a DMA request until it can be dispatched; flag lost requests.
    always_ff @(negedge CLK80) begin
        if (RESET) begin
            dma_pend    <= 1'b0;
            dma_pend_wr <= 1'b0;
            dma_overrun <= 1'b0;
        end else begin
            if (bus.DMA_REQ) begin
                dma_pend_wr <= bus.DMA_WRITE;
                if (dma_pend)
                    dma_overrun <= 1'b1;
            end
            if (disp_op == OP_DMA)
                dma_pend <= 1'b0;
            else if (bus.DMA_REQ)
                dma_pend <= 1'b1;
        end
    end

    // Re-arm CPU dispatch only after the held request has been dropped.
    always_ff @(negedge CLK80) begin
        if (RESET)
            cpu_armed <= 1'b1;
        else if (disp_op == OP_CPU)
            cpu_armed <= 1'b0;
        else if (!bus.CPU_REQ)
            cpu_armed <= 1'b1;
    end

    // Dispatch FSM with registered strobes and watchdog.
    always_ff @(negedge CLK80) begin
        if (RESET) begin
            state       <= ST_IDLE;
            seq_start   <= 1'b0;
            seq_op      <= OP_NONE;
            seq_write   <= 1'b0;
            cpu_grant   <= 1'b0;
            busy        <= 1'b0;
            wdog        <= 8'd0;
            seq_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    seq_start <= 1'b0;
                    cpu_grant <= 1'b0;
                    busy      <= 1'b0;
                    if (disp_op != OP_NONE) begin
                        seq_start <= 1'b1;
                        seq_op    <= disp_op;
                        seq_write <= disp_write;
                        cpu_grant <= (disp_op == OP_CPU);
                        wdog      <= 8'd0;
                        state     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    seq_start <= 1'b0;
                    cpu_grant <= 1'b0;
                    if (bus.SEQ_DONE) begin
                        seq_op    <= OP_NONE;
                        seq_write <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (wdog == TIMEOUT - 8'd1) begin
                        seq_timeout <= 1'b1;
                        seq_op      <= OP_NONE;
                        seq_write   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 8'd1;
                        busy <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SEQ_START   = seq_start;
    assign bus.SEQ_OP      = seq_op;
    assign bus.SEQ_WRITE   = seq_write;
    assign bus.CPU_GRANT   = cpu_grant;
    assign bus.REF_PENDING = ref_pending;
    assign bus.BUSY        = busy;
    assign bus.DMA_OVERRUN = dma_overrun;
    assign bus.REF_OVERRUN = ref_overrun;
    assign bus.SEQ_TIMEOUT = seq_timeout;

endmodule

// File: tb/tb_u712_chip_ram_arbiter.sv
// Directed bench for u712_chip_ram_arbiter. Inputs change on the rising
// edge, the DUT updates on the falling edge, outputs are checked on the
// following rising edge.
module tb_u712_chip_ram_arbiter;

    logic CLK80;
    logic RESET;
    int   vectors;
    int   miscompares;
    int   starts;
    int   busy_cnt;

    u712_chip_ram_arbiter_if bus();

    u712_chip_ram_arbiter dut (
        .CLK80 (CLK80),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK80 = 1'b0;
        forever #5 CLK80 = ~CLK80;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One falling (DUT) edge, then return at the next rising edge.
    task automatic cyc();
        @(negedge CLK80);
        @(posedge CLK80);
    endtask

    task automatic clear_inputs();
        bus.CFG_DONE   = 1'b0;
        bus.DMA_REQ    = 1'b0;
        bus.DMA_WRITE  = 1'b0;
        bus.DBR_ACTIVE = 1'b0;
        bus.CPU_REQ    = 1'b0;
        bus.CPU_WRITE  = 1'b0;
        bus.SEQ_DONE   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        RESET = 1'b1;
        @(posedge CLK80);

        // Reset values, with requests present during reset
        bus.CFG_DONE = 1'b1;
        bus.CPU_REQ  = 1'b1;
        bus.DMA_REQ  = 1'b1;
        cyc();
        cyc();
        cyc();
        check("rst_seq_start", bus.SEQ_START, 1'b0);
        check("rst_seq_op", bus.SEQ_OP, 2'b00);
        check("rst_seq_write", bus.SEQ_WRITE, 1'b0);
        check("rst_cpu_grant", bus.CPU_GRANT, 1'b0);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_ref_pending", bus.REF_PENDING, 3'd0);
        check("rst_flags", {bus.DMA_OVERRUN, bus.REF_OVERRUN, bus.SEQ_TIMEOUT}, 3'b000);

        // Init gating: CPU held while CFG_DONE low
        clear_inputs();
        RESET         = 1'b0;
        bus.CPU_REQ   = 1'b1;
        bus.CPU_WRITE = 1'b1;
        starts = 0;
        repeat (100) begin
            cyc();
            if (bus.SEQ_START) starts++;
        end
        check("gate_no_start", starts, 0);
        bus.CFG_DONE = 1'b1;
        cyc();
        check("gate_cpu_start", bus.SEQ_START, 1'b1);
        check("gate_cpu_op", bus.SEQ_OP, 2'b10);
        check("gate_cpu_grant", bus.CPU_GRANT, 1'b1);
        check("gate_cpu_write", bus.SEQ_WRITE, 1'b1);
        cyc();
        check("gate_start_one_clk", bus.SEQ_START, 1'b0);
        check("gate_grant_one_clk", bus.CPU_GRANT, 1'b0);
        check("gate_busy", bus.BUSY, 1'b1);
        check("gate_op_hold", bus.SEQ_OP, 2'b10);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        check("gate_done_op", bus.SEQ_OP, 2'b00);
        check("gate_done_busy", bus.BUSY, 1'b0);
        check("gate_done_write", bus.SEQ_WRITE, 1'b0);
        cyc();
        check("held_req_no_redispatch", bus.SEQ_START, 1'b0);

        // Priority: DMA beats CPU in the same clock, CPU follows after one idle clock
        do_reset();
        bus.CFG_DONE = 1'b1;
        bus.DMA_REQ  = 1'b1;
        bus.CPU_REQ  = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        check("prio_dma_start", bus.SEQ_START, 1'b1);
        check("prio_dma_op", bus.SEQ_OP, 2'b11);
        check("prio_dma_no_grant", bus.CPU_GRANT, 1'b0);
        cyc();
        cyc();
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        check("prio_gap_no_start", bus.SEQ_START, 1'b0);
        check("prio_gap_op", bus.SEQ_OP, 2'b00);
        cyc();
        check("prio_cpu_start", bus.SEQ_START, 1'b1);
        check("prio_cpu_op", bus.SEQ_OP, 2'b10);
        check("prio_cpu_grant", bus.CPU_GRANT, 1'b1);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        bus.CPU_REQ  = 1'b0;

        // Window: CPU blocked at SLOT_CNT=15, allowed at SLOT_CNT=10
        do_reset();
        bus.CFG_DONE   = 1'b1;
        bus.DBR_ACTIVE = 1'b1;
        bus.DMA_REQ    = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        check("win_dma_op", bus.SEQ_OP, 2'b11);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        repeat (14) cyc();
        bus.CPU_REQ = 1'b1;
        starts = 0;
        repeat (5) begin
            cyc();
            if (bus.SEQ_START) starts++;
        end
        check("win_cpu_blocked_remain7", starts, 0);
        bus.CPU_REQ = 1'b0;
        cyc();
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ  = 1'b0;
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        repeat (9) cyc();
        bus.CPU_REQ = 1'b1;
        cyc();
        check("win_cpu_remain12_start", bus.SEQ_START, 1'b1);
        check("win_cpu_remain12_op", bus.SEQ_OP, 2'b10);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        bus.CPU_REQ  = 1'b0;

        // Window: background refresh allowed at REMAIN=6
        do_reset();
        bus.CFG_DONE   = 1'b1;
        bus.DBR_ACTIVE = 1'b1;
        starts = 0;
        repeat (630) begin
            cyc();
            if (bus.SEQ_START) starts++;
        end
        check("winref_no_start", starts, 0);
        check("winref_pending1", bus.REF_PENDING, 3'd1);
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        check("winref_dma_first", bus.SEQ_OP, 2'b11);
        repeat (15) cyc();
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        check("winref_done_no_start", bus.SEQ_START, 1'b0);
        cyc();
        check("winref_ref_start", bus.SEQ_START, 1'b1);
        check("winref_ref_op", bus.SEQ_OP, 2'b01);
        check("winref_ref_write", bus.SEQ_WRITE, 1'b0);
        check("winref_pending0", bus.REF_PENDING, 3'd0);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;

        // Refresh debt saturation, urgent refresh, reset mid-operation
        do_reset();
        repeat (3110) cyc();
        check("debt_saturate", bus.REF_PENDING, 3'd4);
        check("debt_overrun", bus.REF_OVERRUN, 1'b1);
        bus.CFG_DONE = 1'b1;
        bus.DMA_REQ  = 1'b1;
        bus.CPU_REQ  = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        check("debt_dma_beats_urgent", bus.SEQ_OP, 2'b11);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        cyc();
        check("debt_urgent_start", bus.SEQ_START, 1'b1);
        check("debt_urgent_op", bus.SEQ_OP, 2'b01);
        check("debt_pending3", bus.REF_PENDING, 3'd3);
        cyc();
        check("debt_busy", bus.BUSY, 1'b1);
        RESET = 1'b1;
        cyc();
        check("rstmid_busy", bus.BUSY, 1'b0);
        check("rstmid_op", bus.SEQ_OP, 2'b00);
        check("rstmid_pending", bus.REF_PENDING, 3'd0);
        check("rstmid_flags", {bus.DMA_OVERRUN, bus.REF_OVERRUN, bus.SEQ_TIMEOUT}, 3'b000);
        RESET = 1'b0;

        // DMA overrun, then watchdog timeout
        do_reset();
        bus.CFG_DONE = 1'b1;
        bus.DMA_REQ  = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        cyc();
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        cyc();
        check("ovr_not_yet", bus.DMA_OVERRUN, 1'b0);
        bus.DMA_REQ   = 1'b1;
        bus.DMA_WRITE = 1'b1;
        cyc();
        bus.DMA_REQ   = 1'b0;
        bus.DMA_WRITE = 1'b0;
        check("ovr_set", bus.DMA_OVERRUN, 1'b1);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        check("ovr_gap_no_start", bus.SEQ_START, 1'b0);
        cyc();
        check("ovr_pend_start", bus.SEQ_START, 1'b1);
        check("ovr_pend_op", bus.SEQ_OP, 2'b11);
        check("ovr_pend_write", bus.SEQ_WRITE, 1'b1);
        bus.SEQ_DONE = 1'b1;
        cyc();
        bus.SEQ_DONE = 1'b0;
        starts = 0;
        repeat (3) begin
            cyc();
            if (bus.SEQ_START) starts++;
        end
        check("ovr_single_dma", starts, 0);
        bus.CPU_REQ = 1'b1;
        cyc();
        bus.CPU_REQ = 1'b0;
        check("tmo_cpu_op", bus.SEQ_OP, 2'b10);
        busy_cnt = 0;
        repeat (31) begin
            cyc();
            if (bus.BUSY) busy_cnt++;
        end
        check("tmo_busy_31", busy_cnt, 31);
        check("tmo_not_yet", bus.SEQ_TIMEOUT, 1'b0);
        cyc();
        check("tmo_set", bus.SEQ_TIMEOUT, 1'b1);
        check("tmo_idle_busy", bus.BUSY, 1'b0);
        check("tmo_op_clear", bus.SEQ_OP, 2'b00);
        check("tmo_dma_ovr_sticky", bus.DMA_OVERRUN, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
